// File: rtl/ladder_pkg.sv
// Shared types for the ladder counter receive-side checker.
package ladder_pkg;

  localparam int   MAX_DW = 8;
  localparam logic UP     = 1'b1;
  localparam logic DOWN   = 1'b0;

  typedef enum logic [1:0] {IDLE, ACQUIRE, VERIFY, LOCKED} det_state_t;

  typedef struct packed {
    logic [MAX_DW-1:0] delta;
    logic              dir;
    logic              illegal;
  } step_t;

endpackage

// File: rtl/ladder_step_classify.sv
// Combinational classification of one count step into delta/direction/illegal.
module ladder_step_classify
  import ladder_pkg::*;
#(
  parameter int CW = 4,
  parameter int DW = 3
) (
  input  logic [CW-1:0] count,
  input  logic [CW-1:0] prev,
  input  logic          hold_dir,
  output step_t         step
);

  localparam logic [CW-1:0] LIM = CW'((1 << DW) - 1);

  logic [CW-1:0] diff;
  logic [CW-1:0] neg;

  // Modular subtraction makes a wrap such as 14 -> 1 a legal up step of 3.
  always_comb begin
    diff = count - prev;
    neg  = prev - count;
    step = '0;
    if (diff == '0) begin
      step.dir = hold_dir;
    end else if (diff <= LIM) begin
      step.delta = MAX_DW'(diff);
      step.dir   = UP;
    end else if (neg <= LIM) begin
      step.delta = MAX_DW'(neg);
      step.dir   = DOWN;
    end else begin
      step.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/ladder_delta_detector.sv
// Recovers step size and direction from a ladder count stream and tracks lock.
module ladder_delta_detector
  import ladder_pkg::*;
#(
  parameter int CW     = 4,
  parameter int DW     = 3,
  parameter int LOCK_N = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          count_valid,
  input  logic [CW-1:0] count,
  output logic [DW-1:0] delta_out,
  output logic          direction_out,
  output logic          locked,
  output logic          mismatch
);

  localparam int              MCW      = $clog2(LOCK_N + 1);
  localparam logic [MCW-1:0]  LOCK_MAX = MCW'(LOCK_N);
  localparam det_state_t      AFTER_CAND = (LOCK_N == 1) ? LOCKED : VERIFY;

  det_state_t     state, state_n;
  logic [CW-1:0]  prev, prev_n;
  logic [DW-1:0]  cand_delta, cand_delta_n;
  logic           cand_dir, cand_dir_n;
  logic [MCW-1:0] match_cnt, match_cnt_n;
  logic [DW-1:0]  delta_out_n;
  logic           direction_out_n, locked_n, mismatch_n;

  step_t          step;
  logic [DW-1:0]  step_delta;
  logic           same;

  ladder_step_classify #(.CW(CW), .DW(DW)) u_classify (
    .count    (count),
    .prev     (prev),
    .hold_dir (cand_dir),
    .step     (step)
  );

  // A zero step matches a zero candidate regardless of direction.
  assign step_delta = step.delta[DW-1:0];
  assign same = !step.illegal && (step_delta == cand_delta) &&
                ((step_delta == '0) || (step.dir == cand_dir));

  always_comb begin
    state_n         = state;
    prev_n          = prev;
    cand_delta_n    = cand_delta;
    cand_dir_n      = cand_dir;
    match_cnt_n     = match_cnt;
    delta_out_n     = delta_out;
    direction_out_n = direction_out;
    locked_n        = locked;
    mismatch_n      = 1'b0;
    if (count_valid) begin
      prev_n = count;
      case (state)
        IDLE: state_n = ACQUIRE;
        ACQUIRE: begin
          if (!step.illegal) begin
            cand_delta_n = step_delta;
            cand_dir_n   = step.dir;
            match_cnt_n  = MCW'(1);
            state_n      = AFTER_CAND;
          end
        end
        VERIFY: begin
          if (step.illegal) begin
            match_cnt_n = '0;
            state_n     = ACQUIRE;
          end else if (same) begin
            if (match_cnt + MCW'(1) >= LOCK_MAX) begin
              match_cnt_n = LOCK_MAX;
              state_n     = LOCKED;
            end else begin
              match_cnt_n = match_cnt + MCW'(1);
            end
          end else begin
            cand_delta_n = step_delta;
            cand_dir_n   = step.dir;
            match_cnt_n  = MCW'(1);
          end
        end
        LOCKED: begin
          if (!same) begin
            mismatch_n = 1'b1;
            if (step.illegal) begin
              match_cnt_n = '0;
              state_n     = ACQUIRE;
            end else begin
              cand_delta_n = step_delta;
              cand_dir_n   = step.dir;
              match_cnt_n  = MCW'(1);
              state_n      = AFTER_CAND;
            end
          end
        end
        default: state_n = IDLE;
      endcase
      // A broken pattern always reports unlocked for at least the pulse cycle.
      locked_n = (state_n == LOCKED) && !mismatch_n;
      if (locked_n) begin
        delta_out_n     = cand_delta_n;
        direction_out_n = cand_dir_n;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      prev          <= '0;
      cand_delta    <= '0;
      cand_dir      <= 1'b0;
      match_cnt     <= '0;
      delta_out     <= '0;
      direction_out <= 1'b0;
      locked        <= 1'b0;
      mismatch      <= 1'b0;
    end else begin
      state         <= state_n;
      prev          <= prev_n;
      cand_delta    <= cand_delta_n;
      cand_dir      <= cand_dir_n;
      match_cnt     <= match_cnt_n;
      delta_out     <= delta_out_n;
      direction_out <= direction_out_n;
      locked        <= locked_n;
      mismatch      <= mismatch_n;
    end
  end

endmodule

// File: tb/tb_ladder_delta_detector.sv
// Directed and randomized check of ladder_delta_detector against a run-length reference model.
module tb_ladder_delta_detector;

  localparam int CW     = 4;
  localparam int DW     = 3;
  localparam int LOCK_N = 3;
  localparam int MODV   = 1 << CW;
  localparam int LIM    = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          count_valid = 1'b0;
  logic [CW-1:0] count = '0;
  logic [DW-1:0] delta_out;
  logic          direction_out;
  logic          locked;
  logic          mismatch;

  int errors = 0;
  int checks = 0;

  // Reference: length of the current run of identical legal steps
  int m_started, m_prev, m_run, m_cdelta, m_cdir;
  int e_locked, e_delta, e_dir, e_mis;

  ladder_delta_detector #(.CW(CW), .DW(DW), .LOCK_N(LOCK_N)) dut (
    .clk           (clk),
    .reset         (reset),
    .count_valid   (count_valid),
    .count         (count),
    .delta_out     (delta_out),
    .direction_out (direction_out),
    .locked        (locked),
    .mismatch      (mismatch)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic modelStep(input bit v, input int c, input bit r);
    int d, sd, sdir;
    bit legal;
    if (r) begin
      m_started = 0; m_prev = 0; m_run = 0; m_cdelta = 0; m_cdir = 0;
      e_locked = 0; e_delta = 0; e_dir = 0; e_mis = 0;
      return;
    end
    e_mis = 0;
    if (!v) return;
    if (m_started == 0) begin
      m_started = 1;
    end else begin
      d = (c - m_prev + MODV) % MODV;
      legal = 1'b1;
      sd = 0;
      sdir = m_cdir;
      if (d == 0) begin
        sd = 0;
      end else if (d <= LIM) begin
        sd = d; sdir = 1;
      end else if (MODV - d <= LIM) begin
        sd = MODV - d; sdir = 0;
      end else begin
        legal = 1'b0;
      end
      if (!legal) begin
        if (e_locked != 0) e_mis = 1;
        m_run = 0;
      end else if (m_run > 0 && sd == m_cdelta && (sd == 0 || sdir == m_cdir)) begin
        if (m_run < LOCK_N) m_run++;
      end else begin
        if (e_locked != 0) e_mis = 1;
        m_cdelta = sd;
        m_cdir = sdir;
        m_run = 1;
      end
      e_locked = (m_run >= LOCK_N) ? 1 : 0;
      if (e_locked != 0) begin
        e_delta = m_cdelta;
        e_dir = m_cdir;
      end
    end
    m_prev = c;
  endtask

  task automatic applyStimulus(input string tag, input bit v, input int c, input bit r);
    reset = r;
    count_valid = v;
    count = CW'(c);
    @(posedge clk);
    modelStep(v, c, r);
    @(negedge clk);
    checkOutput({tag, ".locked"}, int'(locked), e_locked);
    checkOutput({tag, ".mismatch"}, int'(mismatch), e_mis);
    checkOutput({tag, ".delta"}, int'(delta_out), e_delta);
    checkOutput({tag, ".dir"}, int'(direction_out), e_dir);
  endtask

  task automatic runSeq(input string tag, input int vals[$]);
    foreach (vals[i]) applyStimulus(tag, 1'b1, vals[i], 1'b0);
  endtask

  initial begin
    int cur, stp, r, p;
    bit v, rs;
    modelStep(1'b0, 0, 1'b1);
    applyStimulus("reset", 1'b0, 0, 1'b1);
    applyStimulus("reset2", 1'b1, 7, 1'b1);

    runSeq("up3", '{0, 3, 6, 9, 12});
    checkOutput("up3_locked_const", int'(locked), 1);
    checkOutput("up3_delta_const", int'(delta_out), 3);
    runSeq("wrap", '{15, 2});
    runSeq("down2", '{15, 13, 11, 9});
    checkOutput("down2_delta_const", int'(delta_out), 2);
    checkOutput("down2_dir_const", int'(direction_out), 0);
    runSeq("break", '{8, 7, 6, 5, 4, 3, 2, 1, 0});
    runSeq("illegal8", '{8, 11, 14, 1, 4, 7});

    applyStimulus("gap", 1'b1, 10, 1'b0);
    applyStimulus("gap", 1'b0, 2, 1'b0);
    applyStimulus("gap", 1'b0, 9, 1'b0);
    applyStimulus("gap", 1'b1, 13, 1'b0);
    applyStimulus("gap", 1'b0, 0, 1'b0);
    applyStimulus("gap", 1'b1, 0, 1'b0);

    applyStimulus("rst_lock", 1'b1, 3, 1'b1);
    checkOutput("rst_lock_const", int'(locked), 0);
    runSeq("const5", '{5, 5, 5, 5, 5});
    checkOutput("const5_delta_const", int'(delta_out), 0);

    cur = 5;
    stp = 2;
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      p = $urandom_range(0, 99);
      rs = (r < 2);
      v = (r >= 25);
      if (v) begin
        if (p < 8) stp = int'($urandom_range(0, 14)) - 7;
        if (p < 5) cur = $urandom_range(0, MODV - 1);
        else cur = (cur + stp + MODV) % MODV;
      end
      applyStimulus("rand", v, cur, rs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
